// File: rtl/usr_pkg.sv
// usr_pkg: shared constants and types for the universal shift register.
// Holds the mode opcodes and the burst FSM state type.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD     = 3'b000;
  localparam logic [2:0] MODE_SHR      = 3'b001;
  localparam logic [2:0] MODE_SHL      = 3'b010;
  localparam logic [2:0] MODE_LOAD     = 3'b011;
  localparam logic [2:0] MODE_ROR      = 3'b100;
  localparam logic [2:0] MODE_ROL      = 3'b101;
  localparam logic [2:0] MODE_ASHR     = 3'b110;
  localparam logic [2:0] MODE_HOLD_ALT = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/usr_burst_ctrl.sv
// usr_burst_ctrl: burst sequencer for univ_shift_reg_n.
// Accepts a start request in IDLE, clamps the length to WIDTH, and then issues
// one shift per enabled clock until the count is exhausted, ending with a
// one-cycle done pulse.
// Ports:
//   clk, clr        clock, asynchronous active-high clear
//   en              clock enable (stalls the count when low)
//   start           burst request, only honoured in IDLE
//   burst_len       requested number of shifts
//   busy            high while in BURST (register decode)
//   done            one-cycle pulse after the last shift
//   shift_pulse     high when the datapath must shift on this edge
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic             shift_pulse
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] len_clamped;

  assign len_clamped = (burst_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : burst_len;

  assign busy        = (state == ST_BURST);
  assign shift_pulse = busy & en;

  // done is a pulse: it is cleared on every edge unless set by that edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (len_clamped == '0) begin
                done <= 1'b1;
              end else begin
                count <= len_clamped;
                state <= ST_BURST;
              end
            end
          end
          ST_BURST: begin
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/univ_shift_reg_n.sv
// univ_shift_reg_n: WIDTH-bit universal shift register with a burst-shift engine.
// Modes: hold, shift right/left, parallel load, rotate right/left, arithmetic
// shift right. A start request runs an N-shift burst in a captured direction.
// Optional feature macro: USR_ROTATE_EN (rotate modes; otherwise they hold).
// Ports:
//   clk, clr                  clock, asynchronous active-high clear
//   en                        clock enable
//   mode                      operation select
//   serial_in_r, serial_in_l  fill bits for right / left shifts
//   parallel_in               load data
//   start, burst_dir, burst_len  burst request, direction (1=left), length
//   q                         register contents
//   serial_out_r, serial_out_l   q[0], q[WIDTH-1]
//   busy, done                burst in progress, burst completion pulse
module univ_shift_reg_n
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             start,
  input  logic             burst_dir,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] q,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic             busy,
  output logic             done
);

  logic dir;
  logic shift_pulse;

  usr_burst_ctrl #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_ctrl (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .start      (start),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .shift_pulse(shift_pulse)
  );

  assign serial_out_r = q[0];
  assign serial_out_l = q[WIDTH-1];

  // Datapath: active burst beats a start request, which beats the mode decode.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q   <= '0;
      dir <= 1'b0;
    end else if (en) begin
      if (shift_pulse) begin
        if (dir) q <= {q[WIDTH-2:0], serial_in_l};
        else     q <= {serial_in_r, q[WIDTH-1:1]};
      end else if (start) begin
        // q holds on the start edge; only the direction is captured.
        dir <= burst_dir;
      end else begin
        case (mode)
          MODE_SHR:  q <= {serial_in_r, q[WIDTH-1:1]};
          MODE_SHL:  q <= {q[WIDTH-2:0], serial_in_l};
          MODE_LOAD: q <= parallel_in;
`ifdef USR_ROTATE_EN
          MODE_ROR:  q <= {q[0], q[WIDTH-1:1]};
          MODE_ROL:  q <= {q[WIDTH-2:0], q[WIDTH-1]};
`endif
          MODE_ASHR: q <= {q[WIDTH-1], q[WIDTH-1:1]};
          default:   q <= q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// tb_univ_shift_reg_n: self-checking bench for univ_shift_reg_n (WIDTH=8).
// Table-driven mode vectors, hand-written burst/clear sequences, and a
// randomized phase compared against an arithmetic reference model.
module tb_univ_shift_reg_n;
  import usr_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          clr;
  logic          en;
  logic [2:0]    mode;
  logic          serial_in_r;
  logic          serial_in_l;
  logic [W-1:0]  parallel_in;
  logic          start;
  logic          burst_dir;
  logic [CW-1:0] burst_len;
  logic [W-1:0]  q;
  logic          serial_out_r;
  logic          serial_out_l;
  logic          busy;
  logic          done;

  univ_shift_reg_n #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .clr         (clr),
    .en          (en),
    .mode        (mode),
    .serial_in_r (serial_in_r),
    .serial_in_l (serial_in_l),
    .parallel_in (parallel_in),
    .start       (start),
    .burst_dir   (burst_dir),
    .burst_len   (burst_len),
    .q           (q),
    .serial_out_r(serial_out_r),
    .serial_out_l(serial_out_l),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: plain integers, remaining-shift count, latched direction.
  int m_q    = 0;
  int m_rem  = 0;
  int m_dir  = 0;
  int m_done = 0;

  task automatic model_reset();
    m_q = 0; m_rem = 0; m_done = 0;
  endtask

  task automatic model_step();
    int nd;
    int n;
    if (clr) begin
      model_reset();
      return;
    end
    nd = 0;
    if (en) begin
      if (m_rem > 0) begin
        if (m_dir != 0) m_q = ((m_q * 2) % 256) + int'(serial_in_l);
        else            m_q = (m_q / 2) + 128 * int'(serial_in_r);
        m_rem = m_rem - 1;
        if (m_rem == 0) nd = 1;
      end else if (start) begin
        n = (int'(burst_len) > 8) ? 8 : int'(burst_len);
        m_dir = int'(burst_dir);
        if (n == 0) nd = 1;
        else m_rem = n;
      end else begin
        case (int'(mode))
          1: m_q = (m_q / 2) + 128 * int'(serial_in_r);
          2: m_q = ((m_q * 2) % 256) + int'(serial_in_l);
          3: m_q = int'(parallel_in);
`ifdef USR_ROTATE_EN
          4: m_q = (m_q / 2) + 128 * (m_q % 2);
          5: m_q = ((m_q * 2) % 256) + (m_q / 128);
`endif
          6: m_q = (m_q / 2) + (m_q / 128) * 128;
          default: ;
        endcase
      end
    end
    m_done = nd;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Runs a window starting with the start edge; en dropped at two indices.
  task automatic run_window(input int cycles, input int stall_a, input int stall_b,
                            output int busy_cnt, output int done_cnt);
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      en = (i == stall_a || i == stall_b) ? 1'b0 : 1'b1;
      tick();
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    en = 1'b1;
  endtask

  typedef struct {
    logic         en;
    logic [2:0]   mode;
    logic         sr;
    logic         sl;
    logic [W-1:0] pin;
    logic [W-1:0] exp_q;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int bc;
    int dc;
    logic [W-1:0] eq;

`ifdef USR_ROTATE_EN
    vecs[9]  = '{1'b1, MODE_ROR, 1'b0, 1'b0, 8'h00, 8'hC0};
`else
    vecs[9]  = '{1'b1, MODE_ROR, 1'b0, 1'b0, 8'h00, 8'h81};
`endif
    vecs[0]  = '{1'b1, MODE_LOAD,     1'b0, 1'b0, 8'hA5, 8'hA5};
    vecs[1]  = '{1'b1, MODE_SHR,      1'b1, 1'b0, 8'h00, 8'hD2};
    vecs[2]  = '{1'b1, MODE_SHL,      1'b0, 1'b0, 8'h00, 8'hA4};
    vecs[3]  = '{1'b0, MODE_LOAD,     1'b0, 1'b0, 8'h00, 8'hA4};
    vecs[4]  = '{1'b1, MODE_HOLD,     1'b1, 1'b1, 8'h00, 8'hA4};
    vecs[5]  = '{1'b1, MODE_HOLD_ALT, 1'b1, 1'b1, 8'hFF, 8'hA4};
    vecs[6]  = '{1'b1, MODE_LOAD,     1'b0, 1'b0, 8'h84, 8'h84};
    vecs[7]  = '{1'b1, MODE_ASHR,     1'b0, 1'b0, 8'h00, 8'hC2};
    vecs[8]  = '{1'b1, MODE_LOAD,     1'b0, 1'b0, 8'h81, 8'h81};
    vecs[10] = '{1'b1, MODE_ROL,      1'b0, 1'b0, 8'h00, 8'h81};
    vecs[11] = '{1'b1, MODE_SHL,      1'b0, 1'b1, 8'h00, 8'h03};
    vecs[12] = '{1'b1, MODE_SHR,      1'b0, 1'b0, 8'h00, 8'h01};

    clr = 1'b1; en = 1'b0; mode = MODE_HOLD; serial_in_r = 1'b0; serial_in_l = 1'b0;
    parallel_in = '0; start = 1'b0; burst_dir = 1'b0; burst_len = '0;
    model_reset();
    tick();
    chk("reset_q", 64'(q), 64'h00);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_done", 64'(done), 64'h0);
    clr = 1'b0;

    // Mode vectors.
    for (int i = 0; i < 13; i++) begin
      en = vecs[i].en; mode = vecs[i].mode; serial_in_r = vecs[i].sr;
      serial_in_l = vecs[i].sl; parallel_in = vecs[i].pin;
      tick();
      eq = vecs[i].exp_q;
      chk($sformatf("vec%0d_q", i), 64'(q), 64'(eq));
      chk($sformatf("vec%0d_sor", i), 64'(serial_out_r), 64'(eq[0]));
      chk($sformatf("vec%0d_sol", i), 64'(serial_out_l), 64'(eq[W-1]));
    end
    en = 1'b1;

    // 4-shift right burst on 0xF0.
    mode = MODE_LOAD; parallel_in = 8'hF0; tick(); mode = MODE_HOLD;
    start = 1'b1; burst_len = 4'd4; burst_dir = 1'b0; serial_in_r = 1'b0;
    run_window(10, -1, -1, bc, dc);
    chk("burst4_busy", 64'(bc), 64'd4);
    chk("burst4_done", 64'(dc), 64'd1);
    chk("burst4_q", 64'(q), 64'h0F);

    // Same burst with en low for two cycles mid-burst.
    mode = MODE_LOAD; parallel_in = 8'hF0; tick(); mode = MODE_HOLD;
    start = 1'b1;
    run_window(12, 2, 3, bc, dc);
    chk("stall_busy", 64'(bc), 64'd6);
    chk("stall_done", 64'(dc), 64'd1);
    chk("stall_q", 64'(q), 64'h0F);

    // Zero-length burst.
    start = 1'b1; burst_len = 4'd0;
    run_window(6, -1, -1, bc, dc);
    chk("len0_busy", 64'(bc), 64'd0);
    chk("len0_done", 64'(dc), 64'd1);
    chk("len0_q", 64'(q), 64'h0F);

    // Over-long burst clamps to 8 left shifts filling ones.
    mode = MODE_LOAD; parallel_in = 8'h00; tick(); mode = MODE_HOLD;
    start = 1'b1; burst_len = 4'd15; burst_dir = 1'b1; serial_in_l = 1'b1;
    run_window(20, -1, -1, bc, dc);
    chk("clamp_busy", 64'(bc), 64'd8);
    chk("clamp_done", 64'(dc), 64'd1);
    chk("clamp_q", 64'(q), 64'hFF);

    // Asynchronous clear in the middle of a burst.
    mode = MODE_LOAD; parallel_in = 8'hF0; tick(); mode = MODE_HOLD;
    start = 1'b1; burst_len = 4'd4; burst_dir = 1'b0; serial_in_r = 1'b0;
    tick(); start = 1'b0;
    tick();
    chk("pre_clr_q", 64'(q), 64'h78);
    #2 clr = 1'b1;
    #1;
    model_reset();
    chk("aclr_q", 64'(q), 64'h00);
    chk("aclr_busy", 64'(busy), 64'h0);
    chk("aclr_done", 64'(done), 64'h0);
    #1 clr = 1'b0;
    run_window(6, -1, -1, bc, dc);
    chk("post_clr_busy", 64'(bc), 64'd0);
    chk("post_clr_done", 64'(dc), 64'd0);

    // start/mode ignored while busy, then back-to-back start with done high.
    mode = MODE_LOAD; parallel_in = 8'h0F; tick();
    mode = MODE_HOLD; start = 1'b1; burst_len = 4'd4; burst_dir = 1'b1; serial_in_l = 1'b0;
    tick();
    chk("ign_start_busy", 64'(busy), 64'h1);
    chk("ign_start_q", 64'(q), 64'h0F);
    mode = MODE_LOAD; parallel_in = 8'hAA; burst_len = 4'd1; burst_dir = 1'b0;
    tick(); chk("ign_q1", 64'(q), 64'h1E);
    tick(); chk("ign_q2", 64'(q), 64'h3C);
    tick(); chk("ign_q3", 64'(q), 64'h78);
    chk("ign_busy3", 64'(busy), 64'h1);
    start = 1'b0; mode = MODE_HOLD;
    tick();
    chk("ign_q4", 64'(q), 64'hF0);
    chk("ign_done", 64'(done), 64'h1);
    chk("ign_idle", 64'(busy), 64'h0);
    start = 1'b1; burst_len = 4'd2; burst_dir = 1'b0; serial_in_r = 1'b1;
    tick(); start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'h1);
    chk("b2b_done_clear", 64'(done), 64'h0);
    tick(); chk("b2b_q1", 64'(q), 64'hF8);
    tick();
    chk("b2b_q2", 64'(q), 64'hFC);
    chk("b2b_done", 64'(done), 64'h1);

    // Randomized phase against the reference model.
    for (int i = 0; i < 400; i++) begin
      clr         = ($urandom_range(0, 49) == 0);
      en          = ($urandom_range(0, 9) != 0);
      mode        = 3'($urandom_range(0, 7));
      start       = ($urandom_range(0, 5) == 0);
      burst_len   = 4'($urandom_range(0, 15));
      burst_dir   = 1'($urandom_range(0, 1));
      serial_in_r = 1'($urandom_range(0, 1));
      serial_in_l = 1'($urandom_range(0, 1));
      parallel_in = 8'($urandom);
      tick();
      chk($sformatf("rand%0d_q", i), 64'(q), 64'(m_q));
      chk($sformatf("rand%0d_busy", i), 64'(busy), 64'(m_rem > 0));
      chk($sformatf("rand%0d_done", i), 64'(done), 64'(m_done));
    end
    clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg_n.md
UNIV_SHIFT_REG_N -- requirements
Module: univ_shift_reg_n

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), width of the burst length field.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clr  input  1  reset, asynchronous and active-high.
REQ-005 en  input  1  clock enable; low = all state holds, burst counter stalls.
REQ-006 mode  input  3  operation select, decoded per REQ-010.
REQ-007 serial_in_r  input  1  bit entering MSB on right shift.
REQ-008 serial_in_l  input  1  bit entering LSB on left shift.
REQ-009 parallel_in  input  WIDTH  load data; also start  input  1, burst_dir  input  1 (0=right, 1=left), burst_len  input  CNT_W; outputs q  output  WIDTH, serial_out_r  output  1 (=q[0]), serial_out_l  output  1 (=q[WIDTH-1]), busy  output  1, done  output  1.

Function
REQ-010 mode decode in IDLE with en=1 and start=0: 000 hold; 001 shift right {serial_in_r,q[W-1:1]}; 010 shift left {q[W-2:0],serial_in_l}; 011 parallel load; 100 rotate right; 101 rotate left; 110 arithmetic shift right (MSB replicated); 111 hold.
REQ-011 Priority: clr > active burst > start > mode.
REQ-012 FSM states IDLE, BURST; DONE is the one-cycle done pulse, not a state.
REQ-013 Edge with en=1, start=1 in IDLE: capture min(burst_len,WIDTH) and burst_dir; q unchanged that edge; enter BURST if count>0.
REQ-014 In BURST, each en=1 edge performs one shift in burst_dir (serial_in_r / serial_in_l as fill), decrements count; en=0 edges leave q and count unchanged.
REQ-015 busy high in every cycle the FSM is in BURST; N-bit burst gives busy high for N enabled edges.
REQ-016 Edge performing the last shift returns FSM to IDLE and sets done high for exactly one cycle.
REQ-017 burst_len=0 at start: no shift, no busy, done high for one cycle after the start edge.
REQ-018 burst_len>WIDTH clamps to WIDTH.
REQ-019 start and mode ignored while busy; start with done high (back-to-back) is accepted normally.
REQ-020 Outputs are registered or direct decodes of registers; no combinational path from inputs to outputs.

Reset
REQ-021 clr high: q=0, FSM=IDLE, count=0, busy=0, done=0, immediately and asynchronously.
REQ-022 clr mid-burst aborts the burst with no done pulse; first operation after clr release is decoded from mode/start.

Configuration
REQ-023 Macro USR_ROTATE_EN defined: mode 100/101 rotate per REQ-010.
REQ-024 USR_ROTATE_EN undefined: mode 100/101 behave as hold; no rotate logic synthesised; all other behaviour identical.

Structure
REQ-025 Package usr_pkg holds mode code constants (MODE_HOLD..MODE_ASHR) and the FSM state typedef.
REQ-026 Burst FSM and down-counter live in sub-module usr_burst_ctrl (inputs clk, clr, en, start, burst_len; outputs busy, done, shift_pulse); datapath stays in univ_shift_reg_n.

Verification
REQ-027 WIDTH=8: clr pulse mid-operation -> q=0x00, busy=0, done=0 same cycle, asynchronously.
REQ-028 load 0xA5, then mode 001 serial_in_r=1 -> q=0xD2; mode 010 serial_in_l=0 -> q=0xA4; mode 110 on 0x84 -> q=0xC2.
REQ-029 USR_ROTATE_EN: q=0x81, mode 100 -> 0xC0, mode 101 -> 0x81; macro undefined -> q stays 0x81.
REQ-030 q=0xF0, start burst_len=4 burst_dir=0 serial_in_r=0 -> busy 4 cycles, q=0x0F, done one cycle; en low 2 cycles mid-burst -> busy 6 cycles, same result.
REQ-031 burst_len=0 -> done one cycle, busy never high, q unchanged; burst_len=15 -> clamped, 8 shifts.
REQ-032 clr at 2nd shift of 4-bit burst -> q=0, no done; start during busy ignored, mode during busy ignored.
